// File: rtl/dma_pkg.sv
// Shared types and constants for the MM2S read-side unpacker.
// Pixel/beat geometry is fixed: 3 x 64-bit beats carry exactly 8 x 24-bit pixels.
package dma_pkg;
  localparam int PIX_W       = 24;
  localparam int BEAT_W      = 64;
  localparam int GROUP_BEATS = 3;
  localparam int GROUP_PIX   = 8;
  localparam int CNT_W       = 26;
  localparam int GROUP_W     = PIX_W * GROUP_PIX;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    FLUSH = 2'd1,
    DONE  = 2'd2
  } rd_state_t;

  // Whole pixels carried by the first `beats` beats of a group: floor(beats*64/24).
  function automatic logic [3:0] pix_per_beats(input logic [1:0] beats);
    logic [7:0] bits;
    bits = {beats, 6'd0};
    return 4'(bits / 8'd24);
  endfunction
endpackage

// File: rtl/pixel_group_serializer.sv
// Drain side of the double buffer: holds one 192-bit group and hands out
// pix_lim pixels, one per data_vld & data_rdy transfer.
module pixel_group_serializer
  import dma_pkg::*;
(
  input  logic               sys_clk,
  input  logic               rst,
  input  logic               load,
  input  logic [GROUP_W-1:0] group,
  input  logic [3:0]         lim,
  input  logic               data_rdy,
  output logic [PIX_W-1:0]   data_out,
  output logic               data_vld,
  output logic               busy,
  output logic               last_pix,
  output logic               last_xfer
);
  logic [GROUP_W-1:0] drain_buf;
  logic [2:0]         pix_idx;
  logic [3:0]         pix_lim;
  logic               vld_q;
  logic               xfer;

  assign xfer      = vld_q & data_rdy;
  assign last_pix  = ({1'b0, pix_idx} == (pix_lim - 4'd1));
  assign last_xfer = xfer & last_pix;
  assign busy      = vld_q;
  assign data_vld  = vld_q;
  assign data_out  = drain_buf[PIX_W*pix_idx +: PIX_W];

  // A load coinciding with the final transfer reuses the slot without a bubble.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      drain_buf <= '0;
      pix_idx   <= '0;
      pix_lim   <= '0;
      vld_q     <= 1'b0;
    end else if (load) begin
      drain_buf <= group;
      pix_idx   <= '0;
      pix_lim   <= lim;
      vld_q     <= 1'b1;
    end else if (xfer) begin
      if (last_pix) vld_q   <= 1'b0;
      else          pix_idx <= pix_idx + 3'd1;
    end
  end
endmodule

// File: rtl/dma_read_unpack.sv
// MM2S AXI4-Stream sink: unpacks 64-bit beats into 24-bit pixels, trims frame
// padding, flags the last pixel and records short-frame / tkeep errors.
module dma_read_unpack
  import dma_pkg::*;
(
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              frame_rst,
  input  logic [CNT_W-1:0]  frame_pixels,
  input  logic [BEAT_W-1:0] M_AXIS_MM2S_tdata,
  input  logic [7:0]        M_AXIS_MM2S_tkeep,
  input  logic              M_AXIS_MM2S_tlast,
  input  logic              M_AXIS_MM2S_tvalid,
  output logic              M_AXIS_MM2S_tready,
  output logic [PIX_W-1:0]  data_out,
  output logic              data_vld,
  input  logic              data_rdy,
  output logic              data_end,
  output logic              err_short,
  output logic              err_keep,
  output rd_state_t         state_dbg
);
  // Handshakes: a beat moves on a cycle where tvalid & tready are both high, a
  // pixel on data_vld & data_rdy; a valid source holds its payload until taken.
  logic               rst;
  rd_state_t          state, state_nx;
  logic [GROUP_W-1:0] fill_buf, assembled, ser_group;
  logic [1:0]         beat_cnt;
  logic               fill_full, fill_end, drain_end;
  logic [3:0]         fill_lim, ppb_now, close_lim, ser_lim;
  logic [CNT_W-1:0]   unassigned, unassigned_eff, remaining;
  logic               started, tlast_seen, end_done;
  logic               hs, fill_hs, enough, close_now, close_end, load_end;
  logic               ser_load, ser_busy, ser_last_pix, ser_last_xfer;

  assign rst = sys_rst | frame_rst;
  assign M_AXIS_MM2S_tready = ~fill_full & (state != DONE) & ~tlast_seen & ~rst;
  assign hs      = M_AXIS_MM2S_tvalid & M_AXIS_MM2S_tready;
  assign fill_hs = hs & (state == FILL);

  // unassigned = frame pixels not yet given to any group; frame_pixels is used
  // directly on the first beat of the frame.
  assign unassigned_eff = started ? unassigned : frame_pixels;
  assign ppb_now   = pix_per_beats(beat_cnt + 2'd1);
  assign enough    = (CNT_W'(ppb_now) >= unassigned_eff);
  assign close_end = M_AXIS_MM2S_tlast | enough;
  assign close_now = fill_hs & ((beat_cnt == 2'd2) | close_end);
  assign close_lim = enough ? unassigned_eff[3:0] : ppb_now;
  assign assembled = fill_buf | (GROUP_W'(M_AXIS_MM2S_tdata) << (BEAT_W*beat_cnt));

  // A closing beat bypasses fill_buf when the drain side is free, giving one-cycle latency.
  assign ser_load  = (fill_full | close_now) & (~ser_busy | ser_last_xfer);
  assign ser_group = fill_full ? fill_buf : assembled;
  assign ser_lim   = fill_full ? fill_lim : close_lim;
  assign load_end  = fill_full ? fill_end : close_end;

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state      <= FILL;
      fill_buf   <= '0;
      beat_cnt   <= '0;
      fill_full  <= 1'b0;
      fill_lim   <= '0;
      fill_end   <= 1'b0;
      drain_end  <= 1'b0;
      unassigned <= '0;
      remaining  <= '0;
      started    <= 1'b0;
      tlast_seen <= 1'b0;
      end_done   <= 1'b0;
      err_short  <= 1'b0;
      err_keep   <= 1'b0;
    end else begin
      state <= state_nx;
      if (hs && !started) begin
        started   <= 1'b1;
        remaining <= frame_pixels;
      end else if (data_vld && data_rdy && remaining != '0) begin
        remaining <= remaining - CNT_W'(1);
      end
      if (hs && M_AXIS_MM2S_tkeep != 8'hFF) err_keep <= 1'b1;
      if (hs && M_AXIS_MM2S_tlast) tlast_seen <= 1'b1;
      if (data_vld && data_rdy && data_end) end_done <= 1'b1;
      if (ser_load) drain_end <= load_end;

      if (close_now) begin
        unassigned <= enough ? '0 : unassigned_eff - CNT_W'(ppb_now);
        if (M_AXIS_MM2S_tlast && !enough) err_short <= 1'b1;
        beat_cnt <= '0;
        if (ser_load) begin
          fill_buf <= '0;
        end else begin
          fill_buf  <= assembled;
          fill_full <= 1'b1;
          fill_lim  <= close_lim;
          fill_end  <= close_end;
        end
      end else if (fill_hs) begin
        unassigned <= unassigned_eff;
        fill_buf   <= assembled;
        beat_cnt   <= beat_cnt + 2'd1;
      end else if (fill_full && ser_load) begin
        fill_full <= 1'b0;
        fill_buf  <= '0;
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      FILL: begin
        if (close_now && close_end && !M_AXIS_MM2S_tlast) state_nx = FLUSH;
        else if (tlast_seen && end_done)                  state_nx = DONE;
      end
      FLUSH:   if (tlast_seen && end_done) state_nx = DONE;
      DONE:    state_nx = DONE;
      default: state_nx = FILL;
    endcase
  end

  assign state_dbg = state;
  // A truncated frame ends on the last pixel of its tlast group, before remaining hits 1.
  assign data_end  = data_vld & ((remaining == CNT_W'(1)) | (drain_end & ser_last_pix));

  pixel_group_serializer u_ser (
    .sys_clk   (sys_clk),
    .rst       (rst),
    .load      (ser_load),
    .group     (ser_group),
    .lim       (ser_lim),
    .data_rdy  (data_rdy),
    .data_out  (data_out),
    .data_vld  (data_vld),
    .busy      (ser_busy),
    .last_pix  (ser_last_pix),
    .last_xfer (ser_last_xfer)
  );
endmodule
